// File: rtl/imem_loader_pkg.sv
// Shared types for the boot-time instruction memory loader.
package imem_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_DONE
   } state_t;

   localparam int LP_BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words and writes them to
// instruction RAM from word 0, holding the core in reset until the program is complete.
//
// state   | meaning
// IDLE    | core released, waiting for istart
// HDR     | collecting the 4-byte word count
// DATA    | collecting program bytes, one RAM write per completed word
// DONE    | single-cycle completion pulse, core still held
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int MP_DATA_WIDTH = 32,
   parameter int MP_ADDR_WIDTH = 8,
   parameter int MP_TIMEOUT    = 1000000
) (
   input  logic                     iclk,
   input  logic                     irst_n,
   input  logic                     istart,
   input  logic [7:0]               ibyte,
   input  logic                     ivalid,
   output logic                     ordy,
   output logic                     owe,
   output logic [MP_ADDR_WIDTH-1:0] owaddr,
   output logic [MP_DATA_WIDTH-1:0] owdata,
   output logic                     ocpu_rst_n,
   output logic                     obusy,
   output logic                     odone,
   output logic                     oerr
);

   localparam int                     LP_BC_W      = $clog2(LP_BYTES_PER_WORD);
   localparam int                     LP_TMO_W     = $clog2(MP_TIMEOUT);
   localparam logic [31:0]            LP_DEPTH     = 32'(1) << MP_ADDR_WIDTH;
   localparam logic [LP_TMO_W-1:0]    LP_TMO_LOAD  = LP_TMO_W'(MP_TIMEOUT - 1);
   localparam logic [MP_ADDR_WIDTH:0] LP_WORD_ONE  = (MP_ADDR_WIDTH+1)'(1);
   localparam logic [LP_BC_W-1:0]     LP_LAST_BYTE = LP_BC_W'(LP_BYTES_PER_WORD - 1);

   state_t                     state, state_nxt;
   logic [LP_BC_W-1:0]         byte_cnt, byte_cnt_nxt;
   logic [MP_ADDR_WIDTH:0]     words_left, words_nxt;
   logic [LP_TMO_W-1:0]        tmo_cnt, tmo_nxt;
   logic                       ordy_nxt, owe_nxt, cpu_nxt, busy_nxt, done_nxt, err_nxt;
   logic [MP_ADDR_WIDTH-1:0]   owaddr_nxt;
   logic [MP_DATA_WIDTH-1:0]   owdata_nxt;
   logic [MP_DATA_WIDTH-1:0]   hdr_word;
   logic                       accept;
   logic                       tmo_expire;

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state      <= ST_IDLE;
         byte_cnt   <= '0;
         words_left <= '0;
         tmo_cnt    <= '0;
         ordy       <= 1'b0;
         owe        <= 1'b0;
         owaddr     <= '0;
         owdata     <= '0;
         ocpu_rst_n <= 1'b0;
         obusy      <= 1'b0;
         odone      <= 1'b0;
         oerr       <= 1'b0;
      end else begin
         state      <= state_nxt;
         byte_cnt   <= byte_cnt_nxt;
         words_left <= words_nxt;
         tmo_cnt    <= tmo_nxt;
         ordy       <= ordy_nxt;
         owe        <= owe_nxt;
         owaddr     <= owaddr_nxt;
         owdata     <= owdata_nxt;
         ocpu_rst_n <= cpu_nxt;
         obusy      <= busy_nxt;
         odone      <= done_nxt;
         oerr       <= err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      byte_cnt_nxt = byte_cnt;
      words_nxt    = words_left;
      tmo_nxt      = tmo_cnt;
      ordy_nxt     = ordy;
      owe_nxt      = 1'b0;
      owaddr_nxt   = owaddr;
      owdata_nxt   = owdata;
      cpu_nxt      = ocpu_rst_n;
      busy_nxt     = obusy;
      done_nxt     = 1'b0;
      err_nxt      = oerr;
      tmo_expire   = 1'b0;
      accept       = ivalid && ordy;
      hdr_word     = {ibyte, owdata[MP_DATA_WIDTH-9:0]};

      // Header and data bytes share the word assembly register.
      if (accept) begin
         owdata_nxt[{byte_cnt, 3'b000} +: 8] = ibyte;
         byte_cnt_nxt = byte_cnt + 1'b1;
         tmo_nxt      = LP_TMO_LOAD;
      end

      case (state)
         ST_IDLE: begin
            cpu_nxt  = 1'b1;
            ordy_nxt = 1'b0;
            busy_nxt = 1'b0;
            if (istart) begin
               state_nxt    = ST_HDR;
               err_nxt      = 1'b0;
               byte_cnt_nxt = '0;
               owaddr_nxt   = '0;
               tmo_nxt      = LP_TMO_LOAD;
               ordy_nxt     = 1'b1;
               busy_nxt     = 1'b1;
               cpu_nxt      = 1'b0;
            end
         end
         ST_HDR: begin
            if (accept) begin
               if (byte_cnt == LP_LAST_BYTE) begin
                  if (hdr_word == '0) begin
                     state_nxt = ST_DONE;
                     done_nxt  = 1'b1;
                     ordy_nxt  = 1'b0;
                  end else begin
                     state_nxt = ST_DATA;
                     if (hdr_word > LP_DEPTH) begin
                        words_nxt = LP_DEPTH[MP_ADDR_WIDTH:0];
                        err_nxt   = 1'b1;
                     end else begin
                        words_nxt = hdr_word[MP_ADDR_WIDTH:0];
                     end
                  end
               end
            end else if (tmo_cnt == '0) begin
               tmo_expire = 1'b1;
            end else begin
               tmo_nxt = tmo_cnt - 1'b1;
            end
         end
         ST_DATA: begin
            if (owe && words_left == '0) begin
               state_nxt = ST_DONE;
               done_nxt  = 1'b1;
            end else begin
               // Address stays on the last written word so it never wraps.
               if (owe) begin
                  owaddr_nxt = owaddr + 1'b1;
               end
               if (accept) begin
                  if (byte_cnt == LP_LAST_BYTE) begin
                     owe_nxt   = 1'b1;
                     words_nxt = words_left - LP_WORD_ONE;
                     if (words_left == LP_WORD_ONE) begin
                        ordy_nxt = 1'b0;
                     end
                  end
               end else if (tmo_cnt == '0) begin
                  tmo_expire = 1'b1;
               end else begin
                  tmo_nxt = tmo_cnt - 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
            cpu_nxt   = 1'b1;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (tmo_expire) begin
         state_nxt = ST_IDLE;
         err_nxt   = 1'b1;
         ordy_nxt  = 1'b0;
         busy_nxt  = 1'b0;
         cpu_nxt   = 1'b1;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 4-word memory and a 16-cycle byte timeout.
module tb_imem_loader;

   localparam int AW  = 2;
   localparam int TMO = 16;

   logic          iclk   = 1'b0;
   logic          irst_n = 1'b0;
   logic          istart = 1'b0;
   logic [7:0]    ibyte  = 8'h00;
   logic          ivalid = 1'b0;
   logic          ordy;
   logic          owe;
   logic [AW-1:0] owaddr;
   logic [31:0]   owdata;
   logic          ocpu_rst_n;
   logic          obusy;
   logic          odone;
   logic          oerr;

   int checks = 0;
   int errors = 0;

   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];
   int            done_cnt    = 0;
   int            viol        = 0;
   int            cyc         = 0;
   int            last_we_cyc = 0;
   int            done_cyc    = 0;

   always #5 iclk = ~iclk;

   imem_loader #(
      .MP_DATA_WIDTH (32),
      .MP_ADDR_WIDTH (AW),
      .MP_TIMEOUT    (TMO)
   ) dut (
      .iclk       (iclk),
      .irst_n     (irst_n),
      .istart     (istart),
      .ibyte      (ibyte),
      .ivalid     (ivalid),
      .ordy       (ordy),
      .owe        (owe),
      .owaddr     (owaddr),
      .owdata     (owdata),
      .ocpu_rst_n (ocpu_rst_n),
      .obusy      (obusy),
      .odone      (odone),
      .oerr       (oerr)
   );

   // Write-port / status log, sampled mid-cycle
   always @(negedge iclk) begin
      cyc = cyc + 1;
      if (owe) begin
         wr_addr.push_back(owaddr);
         wr_data.push_back(owdata);
         last_we_cyc = cyc;
      end
      if (odone) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (obusy && ocpu_rst_n) viol = viol + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   task automatic clr_log();
      wr_addr.delete();
      wr_data.delete();
      done_cnt = 0;
      viol     = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok;
      ok = 1'b0;
      ivalid = 1'b0;
      repeat (gap) tick();
      ibyte  = b;
      ivalid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         if (ordy) begin
            ok = 1'b1;
            tick();
            break;
         end
         tick();
      end
      if (!ok) chk("rdy_wait", 32'(ok), 32'd1);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
   endtask

   task automatic start_load();
      istart = 1'b1;
      tick();
      istart = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (obusy && n < 100) begin
         tick();
         n = n + 1;
      end
      chk("idle_wait", 32'(obusy), 32'd0);
   endtask

   task automatic check_wr(input int i, input logic [AW-1:0] a, input logic [31:0] d);
      if (wr_addr.size() > i) begin
         chk($sformatf("wr%0d_addr", i), 32'(wr_addr[i]), 32'(a));
         chk($sformatf("wr%0d_data", i), wr_data[i], d);
      end else begin
         chk($sformatf("wr%0d_present", i), 32'(wr_addr.size()), 32'(i + 1));
      end
   endtask

   task automatic check_reset_vals(input string pfx);
      chk({pfx, "_ordy"}, 32'(ordy), 32'd0);
      chk({pfx, "_owe"}, 32'(owe), 32'd0);
      chk({pfx, "_owaddr"}, 32'(owaddr), 32'd0);
      chk({pfx, "_owdata"}, owdata, 32'd0);
      chk({pfx, "_cpu"}, 32'(ocpu_rst_n), 32'd0);
      chk({pfx, "_busy"}, 32'(obusy), 32'd0);
      chk({pfx, "_done"}, 32'(odone), 32'd0);
      chk({pfx, "_err"}, 32'(oerr), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] w;

      // Reset values and core release
      clr_log();
      repeat (3) tick();
      check_reset_vals("rst");
      #3 irst_n = 1'b1;
      chk("cpu_hold", 32'(ocpu_rst_n), 32'd0);
      tick();
      chk("cpu_release", 32'(ocpu_rst_n), 32'd1);
      repeat (5) tick();
      chk("idle_ordy", 32'(ordy), 32'd0);
      chk("idle_writes", 32'(wr_addr.size()), 32'd0);

      // Two-word program, back-to-back bytes
      clr_log();
      start_load();
      chk("t2_busy", 32'(obusy), 32'd1);
      chk("t2_ordy", 32'(ordy), 32'd1);
      chk("t2_cpu", 32'(ocpu_rst_n), 32'd0);
      send_word(32'd2, 0);
      send_word(32'h0010_0513, 0);
      send_word(32'h0020_0593, 0);
      ivalid = 1'b0;
      wait_idle(n);
      chk("t2_nwr", 32'(wr_addr.size()), 32'd2);
      check_wr(0, 2'd0, 32'h0010_0513);
      check_wr(1, 2'd1, 32'h0020_0593);
      chk("t2_done_cnt", 32'(done_cnt), 32'd1);
      chk("t2_done_lag", 32'(done_cyc - last_we_cyc), 32'd1);
      chk("t2_err", 32'(oerr), 32'd0);
      chk("t2_cpu_after", 32'(ocpu_rst_n), 32'd1);
      chk("t2_cpu_low", 32'(viol), 32'd0);

      // Zero-length header
      clr_log();
      start_load();
      send_word(32'd0, 0);
      ivalid = 1'b0;
      wait_idle(n);
      chk("t3_nwr", 32'(wr_addr.size()), 32'd0);
      chk("t3_done_cnt", 32'(done_cnt), 32'd1);
      chk("t3_err", 32'(oerr), 32'd0);
      chk("t3_cpu", 32'(ocpu_rst_n), 32'd1);

      // Oversized header clamps to the 4-word depth
      clr_log();
      start_load();
      send_word(32'd6, 0);
      chk("t4_err_set", 32'(oerr), 32'd1);
      for (int i = 0; i < 4; i++) begin
         w = {8'hC0, 8'hB0, 8'(8'hA0 + i), 8'(i + 1)};
         send_word(w, 0);
      end
      ibyte  = 8'h55;
      ivalid = 1'b1;
      chk("t4_ordy_extra0", 32'(ordy), 32'd0);
      tick();
      chk("t4_ordy_extra1", 32'(ordy), 32'd0);
      ivalid = 1'b0;
      wait_idle(n);
      chk("t4_nwr", 32'(wr_addr.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         w = {8'hC0, 8'hB0, 8'(8'hA0 + i), 8'(i + 1)};
         check_wr(i, AW'(i), w);
      end
      chk("t4_err_sticky", 32'(oerr), 32'd1);
      chk("t4_done_cnt", 32'(done_cnt), 32'd1);
      chk("t4_owaddr_end", 32'(owaddr), 32'd3);

      // Stall mid-word until timeout
      clr_log();
      start_load();
      chk("t5_err_clr", 32'(oerr), 32'd0);
      send_word(32'd2, 0);
      send_word(32'h0403_0201, 0);
      send_byte(8'h05, 0);
      ivalid = 1'b0;
      wait_idle(n);
      chk("t5_tmo_cycles", 32'(n), 32'(TMO));
      chk("t5_nwr", 32'(wr_addr.size()), 32'd1);
      check_wr(0, 2'd0, 32'h0403_0201);
      chk("t5_done_cnt", 32'(done_cnt), 32'd0);
      chk("t5_err", 32'(oerr), 32'd1);
      chk("t5_cpu", 32'(ocpu_rst_n), 32'd1);
      chk("t5_ordy", 32'(ordy), 32'd0);
      start_load();
      chk("t5_err_restart", 32'(oerr), 32'd0);

      // Asynchronous reset in the middle of DATA
      clr_log();
      send_word(32'd3, 0);
      send_word(32'hAABB_CCDD, 0);
      send_byte(8'h11, 0);
      ibyte  = 8'h22;
      ivalid = 1'b1;
      tick();
      #2 irst_n = 1'b0;
      #1;
      check_reset_vals("amr");
      repeat (2) tick();
      chk("amr_ordy_held", 32'(ordy), 32'd0);
      chk("amr_cpu_held", 32'(ocpu_rst_n), 32'd0);
      #2 irst_n = 1'b1;
      tick();
      chk("amr_cpu_release", 32'(ocpu_rst_n), 32'd1);
      chk("amr_ordy", 32'(ordy), 32'd0);
      ivalid = 1'b0;
      chk("amr_nwr", 32'(wr_addr.size()), 32'd1);

      // Gapped bytes plus a stray istart during DATA
      clr_log();
      start_load();
      send_word(32'd2, 0);
      send_byte(8'h13, 2);
      send_byte(8'h05, 3);
      ivalid = 1'b0;
      istart = 1'b1;
      tick();
      istart = 1'b0;
      chk("t6_busy", 32'(obusy), 32'd1);
      send_byte(8'h10, 1);
      send_byte(8'h00, 0);
      send_byte(8'h93, 4);
      send_byte(8'h05, 0);
      send_byte(8'h20, 5);
      send_byte(8'h00, 1);
      ivalid = 1'b0;
      wait_idle(n);
      chk("t6_nwr", 32'(wr_addr.size()), 32'd2);
      check_wr(0, 2'd0, 32'h0010_0513);
      check_wr(1, 2'd1, 32'h0020_0593);
      chk("t6_done_cnt", 32'(done_cnt), 32'd1);
      chk("t6_err", 32'(oerr), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
